dcpu16_mem_resp: RTL and testbench

//  Memory responder (slave end) for the CPU's two simplified-Wishbone buses, G-BUS and F-BUS.

---
 rtl/dcpu16_mem_resp.sv | 118 +++++++++++
 tb/tb_dcpu16_mem_resp.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcpu16_mem_resp.sv
// rtl/dcpu16_mem_resp.sv - dual simplified-Wishbone slave (G-BUS/F-BUS) arbitrated onto one single-port word RAM
module dcpu16_mem_resp #(
    parameter int AW   = 16,
    parameter int WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] g_adr,
    input  logic        g_stb,
    input  logic        g_wre,
    input  logic [15:0] g_dto,
    output logic [15:0] g_dti,
    output logic        g_ack,
    input  logic [15:0] f_adr,
    input  logic        f_stb,
    input  logic        f_wre,
    input  logic [15:0] f_dto,
    output logic [15:0] f_dti,
    output logic        f_ack
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;

    localparam logic [3:0] WAIT_LAST = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
    localparam logic [1:0] S_AFTER_GRANT = (WAIT > 0) ? S_WAIT : S_ACCESS;

    logic [15:0]   mem [0:(2**AW)-1];

    logic [1:0]    state;
    logic [3:0]    wait_cnt;
    logic          last_f;
    logic          sel_f;
    logic [AW-1:0] adr_q;
    logic          wre_q;
    logic [15:0]   dto_q;
    logic          grant_f;
    logic [15:0]   rd_data;

    // Upper address bits are deliberately ignored so that addresses alias modulo the RAM depth.
    logic          unused_adr_bits;
    assign unused_adr_bits = &{1'b0, g_adr, f_adr};

    // On a tie the port that was not served last wins; last_f starts at 1 so G wins the first tie.
    assign grant_f = f_stb && (!g_stb || !last_f);
    assign rd_data = mem[adr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            last_f   <= 1'b1;
            sel_f    <= 1'b0;
            adr_q    <= '0;
            wre_q    <= 1'b0;
            dto_q    <= 16'h0000;
            g_ack    <= 1'b0;
            f_ack    <= 1'b0;
            g_dti    <= 16'h0000;
            f_dti    <= 16'h0000;
        end else begin
            g_ack <= 1'b0;
            f_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (g_stb || f_stb) begin
                        sel_f    <= grant_f;
                        last_f   <= grant_f;
                        adr_q    <= grant_f ? f_adr[AW-1:0] : g_adr[AW-1:0];
                        wre_q    <= grant_f ? f_wre : g_wre;
                        dto_q    <= grant_f ? f_dto : g_dto;
                        wait_cnt <= 4'd0;
                        state    <= S_AFTER_GRANT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= S_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_ACCESS: begin
                    if (!wre_q) begin
                        if (sel_f) begin
                            f_dti <= rd_data;
                        end else begin
                            g_dti <= rd_data;
                        end
                    end
                    if (sel_f) begin
                        f_ack <= 1'b1;
                    end else begin
                        g_ack <= 1'b1;
                    end
                    state <= S_ACK;
                end
                // stb is still high here for the request just served, so it is not sampled.
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Kept out of the reset branch so the RAM maps to block RAM; rst still suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && state == S_ACCESS && wre_q) begin
            mem[adr_q] <= dto_q;
        end
    end

endmodule

// File: tb/tb_dcpu16_mem_resp.sv
// tb/tb_dcpu16_mem_resp.sv - self-checking bench for dcpu16_mem_resp (WAIT=0/AW=4 and WAIT=3/AW=16)
module tb_dcpu16_mem_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [15:0] g_adr, g_dto, g_dti, f_adr, f_dto, f_dti;
    logic        g_stb, g_wre, g_ack, f_stb, f_wre, f_ack;
    logic [15:0] w_g_adr, w_g_dto, w_g_dti, w_f_adr, w_f_dto, w_f_dti;
    logic        w_g_stb, w_g_wre, w_g_ack, w_f_stb, w_f_wre, w_f_ack;

    dcpu16_mem_resp #(.AW(4), .WAIT(0)) dut (
        .clk(clk), .rst(rst),
        .g_adr(g_adr), .g_stb(g_stb), .g_wre(g_wre), .g_dto(g_dto), .g_dti(g_dti), .g_ack(g_ack),
        .f_adr(f_adr), .f_stb(f_stb), .f_wre(f_wre), .f_dto(f_dto), .f_dti(f_dti), .f_ack(f_ack)
    );

    dcpu16_mem_resp #(.AW(16), .WAIT(3)) dut_w (
        .clk(clk), .rst(rst),
        .g_adr(w_g_adr), .g_stb(w_g_stb), .g_wre(w_g_wre), .g_dto(w_g_dto), .g_dti(w_g_dti), .g_ack(w_g_ack),
        .f_adr(w_f_adr), .f_stb(w_f_stb), .f_wre(w_f_wre), .f_dto(w_f_dto), .f_dti(w_f_dti), .f_ack(w_f_ack)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] model [0:15];
    logic [15:0] wmodel [int];
    logic [15:0] last_rd [0:3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ack_of(input bit d, input bit p);
        case ({d, p})
            2'b00:   return g_ack;
            2'b01:   return f_ack;
            2'b10:   return w_g_ack;
            default: return w_f_ack;
        endcase
    endfunction

    function automatic logic [15:0] dti_of(input bit d, input bit p);
        case ({d, p})
            2'b00:   return g_dti;
            2'b01:   return f_dti;
            2'b10:   return w_g_dti;
            default: return w_f_dti;
        endcase
    endfunction

    task automatic drive(input bit d, input bit p, input logic stb, input logic wre,
                         input logic [15:0] adr, input logic [15:0] dto);
        case ({d, p})
            2'b00:   begin g_stb = stb; g_wre = wre; g_adr = adr; g_dto = dto; end
            2'b01:   begin f_stb = stb; f_wre = wre; f_adr = adr; f_dto = dto; end
            2'b10:   begin w_g_stb = stb; w_g_wre = wre; w_g_adr = adr; w_g_dto = dto; end
            default: begin w_f_stb = stb; w_f_wre = wre; w_f_adr = adr; w_f_dto = dto; end
        endcase
    endtask

    task automatic set_stb(input bit d, input bit p, input logic v);
        case ({d, p})
            2'b00:   g_stb = v;
            2'b01:   f_stb = v;
            2'b10:   w_g_stb = v;
            default: w_f_stb = v;
        endcase
    endtask

    // Reference memory: the word at adr modulo the instance's depth.
    function automatic logic [15:0] mdl_rd(input bit d, input logic [15:0] adr);
        if (d) return wmodel[int'(adr)];
        return model[adr[3:0]];
    endfunction

    task automatic mdl_wr(input bit d, input logic [15:0] adr, input logic [15:0] v);
        if (d) wmodel[int'(adr)] = v;
        else   model[adr[3:0]] = v;
    endtask

    // Raise a request at the next falling edge and hold it until its ack (stb left high on return).
    task automatic xact(input bit d, input bit p, input logic wre, input logic [15:0] adr,
                        input logic [15:0] dto, input int exp_lat, input int max_lat, output int lat);
        bit    got;
        string nm;
        nm = $sformatf("%s%s", d ? "w_" : "", p ? "f" : "g");
        @(negedge clk);
        drive(d, p, 1'b1, wre, adr, dto);
        lat = 0;
        got = 1'b0;
        while (!got && lat < max_lat) begin
            @(posedge clk);
            #1;
            lat++;
            got = ack_of(d, p);
        end
        chk({nm, "_ack_in_bound"}, 32'(got), 32'd1);
        if (got) begin
            if (exp_lat >= 0) chk({nm, "_latency"}, lat, exp_lat);
            if (wre) begin
                mdl_wr(d, adr, dto);
                chk({nm, "_dti_hold_on_write"}, 32'(dti_of(d, p)), 32'(last_rd[{d, p}]));
            end else begin
                chk($sformatf("%s_rd_%h", nm, adr), 32'(dti_of(d, p)), 32'(mdl_rd(d, adr)));
                last_rd[{d, p}] = mdl_rd(d, adr);
            end
        end
    endtask

    task automatic release_port(input bit d, input bit p);
        @(negedge clk);
        set_stb(d, p, 1'b0);
        @(posedge clk);
        #1;
        chk($sformatf("%s%s_ack_one_cycle", d ? "w_" : "", p ? "f" : "g"), 32'(ack_of(d, p)), 32'd0);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (g_ack || f_ack) chk("acks_exclusive", 32'(g_ack & f_ack), 32'd0);
        if (w_g_ack || w_f_ack) chk("w_acks_exclusive", 32'(w_g_ack & w_f_ack), 32'd0);
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        drive(0, 1, 0, 0, 16'h0, 16'h0);
        drive(1, 0, 0, 0, 16'h0, 16'h0);
        drive(1, 1, 0, 0, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++) last_rd[i] = 16'h0000;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_g_ack", 32'(g_ack), 0);
        chk("rst_f_ack", 32'(f_ack), 0);
        chk("rst_g_dti", 32'(g_dti), 0);
        chk("rst_f_dti", 32'(f_dti), 0);
        chk("rst_w_g_dti", 32'(w_g_dti), 0);
        @(negedge clk);
        rst = 1'b0;

        // First tie after reset goes to G; F is served three cycles later
        fork
            begin int l0; xact(0, 0, 1, 16'h0000, 16'h1111, 2, 8, l0); release_port(0, 0); end
            begin int l1; xact(0, 1, 1, 16'h0001, 16'h2222, 5, 8, l1); release_port(0, 1); end
        join

        // Fill the rest of the AW=4 RAM, alternating ports
        for (int i = 2; i < 16; i++) begin
            xact(0, i[0], 1, 16'(i), 16'($urandom), 2, 8, lat);
            release_port(0, i[0]);
        end

        // F writes BEEF to 0x0010 (aliases to 0), G reads it back
        xact(0, 1, 1, 16'h0010, 16'hBEEF, 2, 8, lat); release_port(0, 1);
        xact(0, 0, 0, 16'h0010, 16'h0000, 2, 8, lat); release_port(0, 0);

        // After a lone G grant, the next tie goes to F
        xact(0, 0, 0, 16'h0003, 16'h0000, 2, 8, lat); release_port(0, 0);
        fork
            begin int l2; xact(0, 0, 0, 16'h0004, 16'h0000, 5, 8, l2); release_port(0, 0); end
            begin int l3; xact(0, 1, 0, 16'h0005, 16'h0000, 2, 8, l3); release_port(0, 1); end
        join

        // Continuous G stb walking addresses 0,1,2: acks 3 cycles apart
        xact(0, 0, 0, 16'h0000, 16'h0000, 2, 8, lat);
        xact(0, 0, 0, 16'h0001, 16'h0000, 3, 8, lat);
        xact(0, 0, 0, 16'h0002, 16'h0000, 3, 8, lat);
        release_port(0, 0);

        // F writes 1234 to 0x0013, reads 0x0003
        xact(0, 1, 1, 16'h0013, 16'h1234, 2, 8, lat); release_port(0, 1);
        xact(0, 1, 0, 16'h0003, 16'h0000, 2, 8, lat); release_port(0, 1);

        // stb and fields dropped right after grant: the latched write still completes
        @(negedge clk);
        drive(0, 0, 1, 1, 16'h0007, 16'h7777);
        @(posedge clk); #1;
        chk("viol_no_early_ack", 32'(g_ack), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 16'h0008, 16'h0000);
        @(posedge clk); #1;
        chk("viol_ack", 32'(g_ack), 1);
        model[7] = 16'h7777;
        @(posedge clk); #1;
        chk("viol_ack_one_cycle", 32'(g_ack), 0);
        xact(0, 1, 0, 16'h0007, 16'h0000, 2, 8, lat); release_port(0, 1);
        xact(0, 0, 0, 16'h0008, 16'h0000, 2, 8, lat); release_port(0, 0);

        // WAIT=3 instance: latency 5, dti held across the other port's write
        xact(1, 0, 1, 16'h1234, 16'hCAFE, 5, 16, lat); release_port(1, 0);
        xact(1, 0, 0, 16'h1234, 16'h0000, 5, 16, lat); release_port(1, 0);
        xact(1, 1, 1, 16'h1234, 16'h1111, 5, 16, lat); release_port(1, 1);
        chk("w_g_dti_held", 32'(w_g_dti), 32'hCAFE);
        fork
            begin int l4; xact(1, 0, 0, 16'h1234, 16'h0000, 5, 16, l4); release_port(1, 0); end
            begin int l5; xact(1, 1, 0, 16'h1234, 16'h0000, 11, 16, l5); release_port(1, 1); end
        join

        // Reset in ACCESS of a write drops it without an ack
        xact(0, 0, 1, 16'h0005, 16'h5555, 2, 8, lat); release_port(0, 0);
        @(negedge clk);
        drive(0, 0, 1, 1, 16'h0005, 16'hAAAA);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_access_no_ack", 32'(g_ack), 0);
        chk("rst_mid_g_dti", 32'(g_dti), 0);
        chk("rst_mid_f_dti", 32'(f_dti), 0);
        for (int i = 0; i < 4; i++) last_rd[i] = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        chk("rst_after_no_ack", 32'(g_ack), 0);
        fork
            begin int l6; xact(0, 0, 0, 16'h0005, 16'h0000, 2, 8, l6); release_port(0, 0); end
            begin int l7; xact(0, 1, 0, 16'h0006, 16'h0000, 5, 8, l7); release_port(0, 1); end
        join

        // Randomised traffic on both ports against the reference memory
        fork
            for (int p = 0; p < 2; p++) begin
                fork
                    automatic bit pp = p[0];
                    begin
                        for (int k = 0; k < 30; k++) begin
                            int  lr;
                            bit  keep;
                            xact(0, pp, 1'($urandom), 16'($urandom), 16'($urandom), -1, 6, lr);
                            keep = 1'($urandom);
                            if (!keep || k == 29) begin
                                release_port(0, pp);
                                repeat ($urandom_range(0, 2)) @(negedge clk);
                            end
                        end
                    end
                join_none
            end
        join
        wait fork;

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
